// File: rtl/countdown_timer.sv
// ============================================================================
// Module   : countdown_timer
// Brief    : Loadable down-counter with prescaler, pause/abort and auto-reload.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_timer #(
    parameter int WIDTH = 24,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             reload_en,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam int               c_PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_PW-1:0]  c_PRESC_LAST = c_PW'(DIV - 1);
    localparam logic [c_PW-1:0]  c_PRESC_ONE  = c_PW'(1);
    localparam logic [WIDTH-1:0] c_CNT_ONE    = WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [WIDTH-1:0] r_reload, w_reload_nxt;
    logic [c_PW-1:0]  r_presc, w_presc_nxt;
    logic             r_done, w_done_nxt;
    logic             w_presc_wrap;
    logic             w_last;

    assign w_presc_wrap = (r_presc == c_PRESC_LAST);
    assign w_last       = (r_count == c_CNT_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_presc  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_presc  <= w_presc_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_presc_nxt  = r_presc;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A zero load expires immediately without ever entering RUN.
                if (load_valid) begin
                    w_count_nxt  = load_value;
                    w_reload_nxt = load_value;
                    w_presc_nxt  = '0;
                    if (load_value != '0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                    w_presc_nxt = '0;
                end else if (!pause) begin
                    if (w_presc_wrap) begin
                        w_presc_nxt = '0;
                        if (w_last) begin
                            w_done_nxt = 1'b1;
                            if (reload_en) begin
                                w_count_nxt = r_reload;
                            end else begin
                                w_count_nxt = '0;
                                w_state_nxt = ST_IDLE;
                            end
                        end else begin
                            w_count_nxt = r_count - c_CNT_ONE;
                        end
                    end else begin
                        w_presc_nxt = r_presc + c_PRESC_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign load_ready = (r_state == ST_IDLE);
    assign busy       = (r_state == ST_RUN);
    assign count      = r_count;
    assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// ============================================================================
// Module   : tb_countdown_timer
// Brief    : Self-checking bench for countdown_timer at DIV=1 and DIV=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_timer;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst, load_valid, reload_en, pause, abort;
    logic [W-1:0] load_value;
    logic         rdy1, busy1, done1, rdy4, busy4, done4;
    logic [W-1:0] cnt1, cnt4;

    int total = 0;
    int bad   = 0;

    // Reference: progress is the number of unpaused cycles since load/reload;
    // remaining count = N - progress/DIV, expiry once progress reaches N*DIV.
    bit     m_busy[2];
    bit     m_done[2];
    longint m_n[2];
    longint m_el[2];
    longint m_cnt[2];
    int     m_div[2] = '{1, 4};

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(W), .DIV(1)) u_d1 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy1),
        .load_value(load_value), .reload_en(reload_en), .pause(pause),
        .abort(abort), .count(cnt1), .busy(busy1), .done(done1)
    );

    countdown_timer #(.WIDTH(W), .DIV(4)) u_d4 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy4),
        .load_value(load_value), .reload_en(reload_en), .pause(pause),
        .abort(abort), .count(cnt4), .busy(busy4), .done(done4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            if (rst) begin
                m_busy[i] = 1'b0;
                m_cnt[i]  = 0;
                m_el[i]   = 0;
                m_n[i]    = 0;
            end else if (!m_busy[i]) begin
                if (load_valid) begin
                    m_n[i]   = longint'(load_value);
                    m_cnt[i] = longint'(load_value);
                    m_el[i]  = 0;
                    if (load_value == 0) m_done[i] = 1'b1;
                    else                 m_busy[i] = 1'b1;
                end
            end else if (abort) begin
                m_busy[i] = 1'b0;
                m_cnt[i]  = 0;
            end else if (!pause) begin
                m_el[i]++;
                if (m_el[i] == m_n[i] * m_div[i]) begin
                    m_done[i] = 1'b1;
                    m_el[i]   = 0;
                    if (reload_en) begin
                        m_cnt[i] = m_n[i];
                    end else begin
                        m_cnt[i]  = 0;
                        m_busy[i] = 1'b0;
                    end
                end else begin
                    m_cnt[i] = m_n[i] - m_el[i] / m_div[i];
                end
            end
        end
    endtask

    task automatic check_all();
        chk("d1_count", 32'(cnt1), 32'(m_cnt[0]));
        chk("d1_busy",  32'(busy1), 32'(m_busy[0]));
        chk("d1_ready", 32'(rdy1),  32'(!m_busy[0]));
        chk("d1_done",  32'(done1), 32'(m_done[0]));
        chk("d4_count", 32'(cnt4), 32'(m_cnt[1]));
        chk("d4_busy",  32'(busy4), 32'(m_busy[1]));
        chk("d4_ready", 32'(rdy4),  32'(!m_busy[1]));
        chk("d4_done",  32'(done4), 32'(m_done[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic lv, input logic [W-1:0] val, input logic rel,
                         input logic pa, input logic ab);
        load_valid = lv;
        load_value = val;
        reload_en  = rel;
        pause      = pa;
        abort      = ab;
    endtask

    task automatic idle_steps(input int n);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        idle_steps(2);

        // Load 5, one-shot; DIV=1 expiry latency.
        drive(1'b1, 24'd5, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        lat = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (done1 === 1'b1 && lat == 0) lat = k;
        end
        chk("lat_n5_div1", 32'(lat), 32'd5);

        // Load 3; DIV=4 expiry latency.
        drive(1'b1, 24'd3, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        lat = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (done4 === 1'b1 && lat == 0) lat = k;
        end
        chk("lat_n3_div4", 32'(lat), 32'd12);

        // Periodic mode for 10 cycles, then one-shot.
        drive(1'b1, 24'd3, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) step();
        idle_steps(20);

        // Pause for 4 cycles once the DIV=1 count reaches 4.
        drive(1'b1, 24'd6, 1'b0, 1'b0, 1'b0);
        step();
        idle_steps(2);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step();
        idle_steps(28);

        // Abort at count 3, then an immediate reload.
        drive(1'b1, 24'd8, 1'b0, 1'b0, 1'b0);
        step();
        idle_steps(5);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 24'd2, 1'b0, 1'b0, 1'b1);
        step();
        idle_steps(10);

        // Zero load, then periodic N=1 which pulses done on every DIV=1 cycle.
        drive(1'b1, 24'd0, 1'b0, 1'b1, 1'b1);
        step();
        idle_steps(2);
        drive(1'b1, 24'd1, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) step();
        idle_steps(6);

        // Reset mid-run, and reset overriding a handshake in IDLE.
        drive(1'b1, 24'd100, 1'b0, 1'b0, 1'b0);
        step();
        idle_steps(50);
        rst = 1'b1;
        drive(1'b1, 24'd9, 1'b0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        idle_steps(3);

        // Maximum load value, then abort.
        drive(1'b1, {W{1'b1}}, 1'b0, 1'b0, 1'b0);
        step();
        idle_steps(9);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();
        idle_steps(2);

        for (int k = 0; k < 1500; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive(($urandom_range(0, 3) == 0), W'($urandom_range(0, 6)),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 47) == 0));
            step();
        end
        rst = 1'b0;
        idle_steps(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter WIDTH, default 24: counter and load-value width in bits.
REQ-002 Parameter DIV, default 1, range 1..2^16: clock cycles per count step (prescaler).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 load_valid  in  1  host offers a start value.
REQ-006 load_ready  out  1  timer accepts a start value; high only in IDLE.
REQ-007 load_value  in  WIDTH  start value, sampled on handshake.
REQ-008 reload_en  in  1  1 = periodic (auto-reload) mode; sampled at each expiry.
REQ-009 pause  in  1  level; freezes counting while high.
REQ-010 abort  in  1  level; cancels a running countdown.
REQ-011 count  out  WIDTH  current remaining count (registered).
REQ-012 busy  out  1  high in RUN state.
REQ-013 done  out  1  one-cycle expiry pulse (registered).

Function
REQ-014 States SHALL be IDLE and RUN only; busy = (state == RUN); load_ready = (state == IDLE).
REQ-015 Handshake SHALL occur on an edge where load_valid and load_ready are both high; load_value SHALL then be captured into count and into an internal reload register.
REQ-016 Handshake with load_value != 0 SHALL move IDLE -> RUN and clear the prescaler to 0 on the same edge.
REQ-017 Handshake with load_value == 0 SHALL stay in IDLE, set count = 0, and assert done for exactly the next cycle.
REQ-018 In RUN, the prescaler SHALL increment each unpaused cycle and generate a tick when it equals DIV-1, then wrap to 0; DIV = 1 SHALL tick every unpaused cycle.
REQ-019 On each tick with count > 1, count SHALL decrement by 1.
REQ-020 On a tick with count == 1 (expiry): done SHALL be high in the following cycle; if reload_en = 1, count SHALL take the reload register value and state SHALL remain RUN; otherwise count SHALL become 0 and state SHALL become IDLE.
REQ-021 Latency: with DIV = d and value N, done SHALL be high exactly N*d cycles after the handshake edge, with no pause.
REQ-022 pause = 1 in RUN SHALL hold count and prescaler; no tick and no done SHALL occur; counting SHALL resume from the held prescaler value.
REQ-023 abort = 1 in RUN SHALL force IDLE, count = 0, and prescaler = 0 on the next edge; done SHALL NOT assert.
REQ-024 Priority SHALL be rst > abort > pause > tick.
REQ-025 abort or pause in IDLE SHALL have no effect; a handshake in the same cycle as abort SHALL still be accepted.
REQ-026 load_value and load_valid SHALL be ignored while in RUN.
REQ-027 count SHALL never wrap below 0 or exceed the loaded value; the arithmetic is modulo-free because of REQ-020.
REQ-028 done SHALL never be high for two consecutive cycles, except in reload mode with N = 1 and DIV = 1, where it is high on every cycle.

Reset
REQ-029 While rst is high at an edge, the block SHALL enter IDLE with count = 0, done = 0, busy = 0, the prescaler at 0, and the reload register at 0; load_ready SHALL be 1 in the cycle after the edge.
REQ-030 rst asserted in RUN SHALL abort the countdown with no done pulse; rst SHALL override a same-cycle handshake.

Verification
REQ-031 DIV=1, load 5, reload_en=0 -> count 5,4,3,2,1,0 on successive cycles; done is high once, 5 cycles after the handshake; load_ready returns high with done.
REQ-032 DIV=4, load 3 -> count holds each value for 4 cycles; done is high 12 cycles after the handshake; busy is high for cycles 1..12.
REQ-033 DIV=1, load 3, reload_en=1 for 10 cycles then 0 -> done pulses every 3 cycles; after reload_en drops, the next expiry goes to IDLE with count = 0.
REQ-034 DIV=1, load 6, pause high for 4 cycles after count = 4 -> count stays 4 during the pause; done is high 10 cycles after the handshake.
REQ-035 Load 8, abort at count = 3 -> next cycle IDLE, count = 0, no done pulse; a new load_valid is accepted immediately.
REQ-036 Load 0 -> done is high next cycle, busy stays 0; rst mid-RUN (load 100, rst at count = 50) -> count = 0, no done pulse.
